// File: rtl/rsa_job_sequencer.sv
// Job sequencer for one RSA control core: accepts a job, runs the inverter and
// mod-exp phases with stale-finish guard and timeout, then returns the result.
module rsa_job_sequencer #(
  parameter int WIDTH          = 128,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_p,
  input  logic [WIDTH-1:0]   req_q,
  input  logic               req_encrypt_decrypt,
  input  logic [2*WIDTH-1:0] req_msg,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_msg,
  output logic               rsp_timeout,
  output logic               busy,
  output logic [WIDTH-1:0]   core_p,
  output logic [WIDTH-1:0]   core_q,
  output logic               core_encrypt_decrypt,
  output logic [2*WIDTH-1:0] core_msg_in,
  output logic               core_reset_inverter,
  output logic               core_reset_mod_exp,
  input  logic               core_inverter_finish,
  input  logic               core_mod_exp_finish,
  input  logic [2*WIDTH-1:0] core_msg_out
);

  localparam int            CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE, INV_RST, INV_WAIT, EXP_RST, EXP_WAIT, RESP
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          in_wait, finish_sel, finish_hit, timeout_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // armed is low only on the first edge of a wait state, masking a stale finish
  always_comb begin
    next_state  = state;
    in_wait     = (state == INV_WAIT) || (state == EXP_WAIT);
    finish_sel  = (state == INV_WAIT) ? core_inverter_finish : core_mod_exp_finish;
    finish_hit  = in_wait && armed && finish_sel;
    timeout_hit = in_wait && !finish_hit && TO_EN && (cnt == TO_LIMIT);
    case (state)
      IDLE:     if (req_valid) next_state = INV_RST;
      INV_RST:  next_state = INV_WAIT;
      INV_WAIT: begin
        if (finish_hit)       next_state = EXP_RST;
        else if (timeout_hit) next_state = RESP;
      end
      EXP_RST:  next_state = EXP_WAIT;
      EXP_WAIT: if (finish_hit || timeout_hit) next_state = RESP;
      RESP:     if (rsp_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (!in_wait || (next_state != state)) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (TO_EN) cnt <= cnt + CW'(1);
    end
  end

  // Pulses and rsp_valid are registered decodes of the upcoming state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_p               <= '0;
      core_q               <= '0;
      core_encrypt_decrypt <= 1'b0;
      core_msg_in          <= '0;
      core_reset_inverter  <= 1'b0;
      core_reset_mod_exp   <= 1'b0;
      rsp_valid            <= 1'b0;
      rsp_msg              <= '0;
      rsp_timeout          <= 1'b0;
    end else begin
      core_reset_inverter <= (next_state == INV_RST);
      core_reset_mod_exp  <= (next_state == EXP_RST);
      rsp_valid           <= (next_state == RESP);
      if ((state == IDLE) && req_valid) begin
        core_p               <= req_p;
        core_q               <= req_q;
        core_encrypt_decrypt <= req_encrypt_decrypt;
        core_msg_in          <= req_msg;
      end
      if ((state == EXP_WAIT) && finish_hit) begin
        rsp_msg     <= core_msg_out;
        rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        rsp_msg     <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Directed bench for rsa_job_sequencer: nominal, stale finish, timeout,
// backpressure, busy-time requests and mid-job reset.
module tb_rsa_job_sequencer;

  localparam int W = 128;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           req_valid = 1'b0, req_valid2 = 1'b0;
  logic           rsp_ready = 1'b0, rsp_ready2 = 1'b0;
  logic [W-1:0]   req_p = '0, req_q = '0;
  logic           req_ed = 1'b0;
  logic [2*W-1:0] req_msg = '0;
  logic [2*W-1:0] cmsg = 256'hDEAD;

  logic           req_ready, rsp_valid, rsp_timeout, busy, core_ed, rst_inv, rst_exp;
  logic [2*W-1:0] rsp_msg, core_msg_in;
  logic [W-1:0]   core_p, core_q;
  logic           inv_fin, exp_fin;

  logic           req_ready2, rsp_valid2, rsp_timeout2, busy2, core_ed2, rst_inv2, rst_exp2;
  logic [2*W-1:0] rsp_msg2, core_msg_in2;
  logic [W-1:0]   core_p2, core_q2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rsa_job_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_p(req_p), .req_q(req_q),
    .req_encrypt_decrypt(req_ed), .req_msg(req_msg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_msg(rsp_msg), .rsp_timeout(rsp_timeout),
    .busy(busy), .core_p(core_p), .core_q(core_q), .core_encrypt_decrypt(core_ed),
    .core_msg_in(core_msg_in), .core_reset_inverter(rst_inv), .core_reset_mod_exp(rst_exp),
    .core_inverter_finish(inv_fin), .core_mod_exp_finish(exp_fin), .core_msg_out(cmsg)
  );

  rsa_job_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_p(req_p), .req_q(req_q),
    .req_encrypt_decrypt(req_ed), .req_msg(req_msg),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_msg(rsp_msg2), .rsp_timeout(rsp_timeout2),
    .busy(busy2), .core_p(core_p2), .core_q(core_q2), .core_encrypt_decrypt(core_ed2),
    .core_msg_in(core_msg_in2), .core_reset_inverter(rst_inv2), .core_reset_mod_exp(rst_exp2),
    .core_inverter_finish(1'b0), .core_mod_exp_finish(1'b0), .core_msg_out(256'hBAD)
  );

  // Core model: finish raised a fixed number of cycles after each start pulse
  logic tie_high = 1'b0;
  int   inv_cnt = 0, exp_cnt = 0;
  always @(posedge clk) begin
    if (rst_inv) inv_cnt <= 1; else if (inv_cnt != 0) inv_cnt <= inv_cnt + 1;
    if (rst_exp) exp_cnt <= 1; else if (exp_cnt != 0) exp_cnt <= exp_cnt + 1;
  end
  assign inv_fin = tie_high || (inv_cnt >= 20);
  assign exp_fin = tie_high || (exp_cnt >= 40);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  int edges, exp_hits, exp_first;

  initial begin
    // reset state
    #12;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_p", core_p, 0);
    chk("rst_rsp_msg", rsp_msg, 0);
    chk("rst_pulses", {rst_inv, rst_exp, rsp_timeout}, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_req_ready", req_ready, 1);

    // nominal job
    req_p = 128'd113680897410347;
    req_q = 128'd7999808077935876437321;
    req_ed = 1'b0;
    req_msg = 256'h3e18000000000000000000;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("nom_inv_pulse_hi", rst_inv, 1);
    chk("nom_core_p", core_p, 128'd113680897410347);
    chk("nom_core_q", core_q, 128'd7999808077935876437321);
    chk("nom_core_msg", core_msg_in, 256'h3e18000000000000000000);
    chk("nom_core_ed", core_ed, 0);
    chk("nom_busy", busy, 1);
    tick();
    chk("nom_inv_pulse_lo", rst_inv, 0);
    edges = 1; exp_hits = 0;
    while (!rsp_valid && edges < 200) begin
      tick(); edges++;
      if (rst_exp) exp_hits++;
    end
    chk("nom_latency", edges, 62);
    chk("nom_exp_pulse_width", exp_hits, 1);
    chk("nom_rsp_msg", rsp_msg, 256'hDEAD);
    chk("nom_rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("nom_rsp_drop", rsp_valid, 0);
    chk("nom_back_idle", req_ready, 1);

    // stale finish: both finishes high throughout
    tie_high = 1'b1;
    req_msg = 256'h55;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("stale_inv_pulse", rst_inv, 1);
    edges = 0; exp_hits = 0; exp_first = -1;
    while (!rsp_valid && edges < 50) begin
      tick(); edges++;
      if (rst_exp) begin exp_hits++; if (exp_first < 0) exp_first = edges; end
    end
    chk("stale_latency", edges, 6);
    chk("stale_exp_edge", exp_first, 3);
    chk("stale_exp_width", exp_hits, 1);

    // backpressure, second job queued on req_valid meanwhile
    req_ed = 1'b1;
    req_msg = 256'he100;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_msg", rsp_msg, 256'hDEAD);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_core_msg", core_msg_in, 256'h55);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_handshake_drop", rsp_valid, 0);
    chk("bp_idle_cycle", req_ready, 1);
    chk("bp_not_yet_accepted", core_msg_in, 256'h55);
    tick();
    req_valid = 1'b0;
    chk("job2_accepted", core_msg_in, 256'he100);
    chk("job2_inv_pulse", rst_inv, 1);
    edges = 0;
    while (!rsp_valid && edges < 50) begin
      chk("job2_mode_held", core_ed, 1);
      tick(); edges++;
    end
    chk("job2_latency", edges, 6);
    chk("job2_mode_resp", core_ed, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // request while busy, then reset during EXP_WAIT
    tie_high = 1'b0;
    req_ed = 1'b0;
    req_msg = 256'h1234;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    req_msg = 256'h9999;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("busy_not_ready", req_ready, 0);
    chk("busy_msg_kept", core_msg_in, 256'h1234);
    for (int i = 0; i < 25; i++) tick();
    chk("mid_busy", busy, 1);
    chk("mid_no_rsp", rsp_valid, 0);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_core_msg", core_msg_in, 0);
    chk("arst_core_pq_ed", {core_p, core_q[W-1:1], core_ed}, 0);
    chk("arst_flags", {rst_inv, rst_exp, rsp_valid, rsp_timeout}, 0);
    chk("arst_rsp_msg", rsp_msg, 0);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rsp_valid || !req_ready) chk("post_rst_quiet", {rsp_valid, req_ready}, 2'b01);
    end
    chk("post_rst_ready", req_ready, 1);

    cmsg = 256'hBEEF;
    req_msg = 256'h77;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    edges = 0;
    while (!rsp_valid && edges < 200) begin tick(); edges++; end
    chk("rejob_latency", edges, 62);
    chk("rejob_msg", rsp_msg, 256'hBEEF);
    chk("rejob_timeout", rsp_timeout, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // timeout on the 16-cycle instance, inverter never finishes
    req_valid2 = 1'b1;
    tick();
    req_valid2 = 1'b0;
    chk("to_inv_pulse", rst_inv2, 1);
    edges = 0; exp_hits = 0;
    while (!rsp_valid2 && edges < 100) begin
      tick(); edges++;
      if (rst_exp2) exp_hits++;
    end
    chk("to_latency", edges, 18);
    chk("to_flag", rsp_timeout2, 1);
    chk("to_msg", rsp_msg2, 0);
    chk("to_no_exp_pulse", exp_hits, 0);
    rsp_ready2 = 1'b1;
    tick();
    rsp_ready2 = 1'b0;
    chk("to_idle", req_ready2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
